// File: rtl/sdram_avalon_bridge_pkg.sv
// Shared definitions for the SDRAM arbiter to Avalon-MM bridge.
package sdram_avalon_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_ACK  = 3'd4,
    GUARD   = 3'd5
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/sdram_avalon_bridge.sv
// Bridges one arbiter access (single-word write or aligned linear read burst)
// onto an Avalon-MM master port and returns one ack per completed word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for acc_i; the only state in which idle_o is high
// RD_REQ  | read burst command on the bus until waitrequest drops
// RD_DATA | collecting remaining read beats
// WR_REQ  | single-word write command on the bus until waitrequest drops
// WR_ACK  | one-cycle write acknowledge
// GUARD   | one dead cycle so the requester can drop acc_i
module sdram_avalon_bridge
  import sdram_avalon_bridge_pkg::*;
#(
  parameter int MAX_BUF_WIDTH = 8,
  parameter int BURST_W       = 9
) (
  input  logic               sdram_clk,
  input  logic               sdram_rst,
  input  logic               acc_i,
  input  logic               we_i,
  input  logic [31:0]        adr_i,
  input  logic [31:0]        dat_i,
  input  logic [3:0]         sel_i,
  input  logic [3:0]         buf_width_i,
  output logic               ack_o,
  output logic [31:0]        adr_o,
  output logic [31:0]        dat_o,
  output logic               idle_o,
  output logic [31:0]        avm_address,
  output logic               avm_read,
  output logic               avm_write,
  output logic [BURST_W-1:0] avm_burstcount,
  output logic [3:0]         avm_byteenable,
  output logic [31:0]        avm_writedata,
  input  logic               avm_waitrequest,
  input  logic [31:0]        avm_readdata,
  input  logic               avm_readdatavalid
);

  // Beat index must reach 2^MAX_BUF_WIDTH after the last beat.
  localparam int          BEAT_W = MAX_BUF_WIDTH + 1;
  localparam logic [3:0]  MAX_BW = 4'(MAX_BUF_WIDTH);
  localparam logic [BURST_W-1:0] ONE_WORD = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [31:0] WORD_SHIFT = 32'($clog2(WORD_BYTES));

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [BURST_W-1:0] count_q, count_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [31:0]        wdat_q, wdat_d;
  logic [3:0]         wsel_q, wsel_d;
  logic               ack_q, ack_d;
  logic [31:0]        adr_o_q, adr_o_d;
  logic [31:0]        dat_o_q, dat_o_d;

  logic [3:0]         bw_clamp;
  logic [31:0]        rd_mask;
  logic               last_beat;

  // Clamp the requested burst size and build the alignment mask for it.
  always_comb begin
    bw_clamp = (buf_width_i > MAX_BW) ? MAX_BW : buf_width_i;
    rd_mask  = 32'hFFFF_FFFF << ({1'b0, bw_clamp} + 5'd2);
  end

  assign last_beat = (BURST_W'(beat_q) == (count_q - ONE_WORD));

  // Next-state and datapath updates; acks are registered one cycle after their beat.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    beat_d  = beat_q;
    wdat_d  = wdat_q;
    wsel_d  = wsel_q;
    ack_d   = 1'b0;
    adr_o_d = adr_o_q;
    dat_o_d = dat_o_q;

    case (state_q)
      IDLE: begin
        if (acc_i) begin
          if (we_i) begin
            addr_d  = {adr_i[31:2], 2'b00};
            wdat_d  = dat_i;
            wsel_d  = sel_i;
            count_d = ONE_WORD;
            state_d = WR_REQ;
          end else begin
            addr_d  = adr_i & rd_mask;
            count_d = ONE_WORD << bw_clamp;
            beat_d  = '0;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ, RD_DATA: begin
        if (state_q == RD_REQ && !avm_waitrequest) begin
          state_d = RD_DATA;
        end
        // Data may arrive while the command is still being issued.
        if (avm_readdatavalid) begin
          ack_d   = 1'b1;
          dat_o_d = avm_readdata;
          adr_o_d = addr_q + (32'(beat_q) << WORD_SHIFT);
          beat_d  = beat_q + 1'b1;
          if (last_beat) begin
            state_d = GUARD;
          end
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          ack_d   = 1'b1;
          adr_o_d = addr_q;
          state_d = WR_ACK;
        end
      end
      WR_ACK:  state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register update with synchronous reset; reset abandons any access in flight.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
      wdat_q  <= '0;
      wsel_q  <= '0;
      ack_q   <= 1'b0;
      adr_o_q <= '0;
      dat_o_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      wdat_q  <= wdat_d;
      wsel_q  <= wsel_d;
      ack_q   <= ack_d;
      adr_o_q <= adr_o_d;
      dat_o_q <= dat_o_d;
    end
  end

  // Bus commands are pure decodes of the state register.
  always_comb begin
    avm_read       = (state_q == RD_REQ);
    avm_write      = (state_q == WR_REQ);
    avm_burstcount = '0;
    if (state_q == RD_REQ) begin
      avm_burstcount = count_q;
    end else if (state_q == WR_REQ) begin
      avm_burstcount = ONE_WORD;
    end
  end

  assign idle_o         = (state_q == IDLE);
  assign avm_address    = addr_q;
  assign avm_writedata  = wdat_q;
  assign avm_byteenable = wsel_q;
  assign ack_o          = ack_q;
  assign adr_o          = adr_o_q;
  assign dat_o          = dat_o_q;

endmodule

// File: tb/tb_sdram_avalon_bridge.sv
// Self-checking bench for sdram_avalon_bridge: directed vector table, randomized
// accesses against a queue-based reference model, and hand-written reset/guard sequences.
module tb_sdram_avalon_bridge;

  localparam int MAX_BW  = 8;
  localparam int BURST_W = 9;

  logic               sdram_clk = 1'b0;
  logic               sdram_rst;
  logic               acc_i, we_i;
  logic [31:0]        adr_i, dat_i;
  logic [3:0]         sel_i, buf_width_i;
  logic               ack_o, idle_o;
  logic [31:0]        adr_o, dat_o;
  logic [31:0]        avm_address, avm_writedata, avm_readdata;
  logic               avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [BURST_W-1:0] avm_burstcount;
  logic [3:0]         avm_byteenable;

  sdram_avalon_bridge #(.MAX_BUF_WIDTH(MAX_BW), .BURST_W(BURST_W)) dut (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
    .acc_i(acc_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
    .buf_width_i(buf_width_i),
    .ack_o(ack_o), .adr_o(adr_o), .dat_o(dat_o), .idle_o(idle_o),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_burstcount(avm_burstcount), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 sdram_clk = ~sdram_clk;

  int cyc = 0;
  always @(posedge sdram_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } ack_t;

  ack_t ackq[$];
  int   viol = 0;

  always @(negedge sdram_clk) begin
    if (ack_o) ackq.push_back('{adr_o, dat_o, cyc});
    if (avm_read && avm_write) viol++;
    if (idle_o && ack_o) viol++;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0FF0;
  endfunction

  task automatic step();
    @(negedge sdram_clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (!idle_o && t < 2000) begin
      step();
      t++;
    end
    if (!idle_o) begin
      tests++;
      fails++;
      $display("FAIL %s idle timeout: idle_o stayed low", nm);
    end
  endtask

  // One full access; expected behaviour derived from plain address arithmetic.
  task automatic run_access(input bit we, input logic [31:0] adr, input logic [3:0] bw,
                            input logic [31:0] dat, input logic [3:0] sel, input int waits,
                            input int max_gap, input bit scramble, input string nm);
    int          eff_bw, cnt, cmd_cycles, stab_bad, gap;
    logic [31:0] base, a0, wd0;
    logic [BURST_W-1:0] bc0;
    logic [3:0]  be0;
    ack_t        expq[$];

    wait_idle(nm);
    eff_bw = (int'(bw) > MAX_BW) ? MAX_BW : int'(bw);
    cnt    = we ? 1 : (1 << eff_bw);
    base   = we ? adr - (adr % 4) : adr - (adr % (32'd4 << eff_bw));
    ackq.delete();
    acc_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel; buf_width_i = bw;
    avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0;
    step();
    if (scramble) begin
      acc_i = 1'($urandom); we_i = 1'($urandom); adr_i = $urandom;
      dat_i = $urandom; sel_i = 4'($urandom); buf_width_i = 4'($urandom);
    end
    chk({nm, " cmd"}, {31'b0, we ? avm_write : avm_read}, 32'd1);
    chk({nm, " other cmd"}, {31'b0, we ? avm_read : avm_write}, 32'd0);
    chk({nm, " avm_address"}, avm_address, base);
    chk({nm, " burstcount"}, 32'(avm_burstcount), 32'(cnt));
    if (we) begin
      chk({nm, " writedata"}, avm_writedata, dat);
      chk({nm, " byteenable"}, 32'(avm_byteenable), 32'(sel));
    end
    a0 = avm_address; bc0 = avm_burstcount; wd0 = avm_writedata; be0 = avm_byteenable;
    cmd_cycles = 1; stab_bad = 0;
    for (int i = 0; i < waits; i++) begin
      step();
      if (we ? avm_write : avm_read) cmd_cycles++;
      if (avm_address !== a0 || avm_burstcount !== bc0 ||
          (we && (avm_writedata !== wd0 || avm_byteenable !== be0))) stab_bad++;
    end
    avm_waitrequest = 1'b0;
    if (we) expq.push_back('{base, 32'h0, cyc + 1});
    step();
    avm_waitrequest = 1'b1;
    chk({nm, " cmd held cycles"}, 32'(cmd_cycles), 32'(waits + 1));
    chk({nm, " cmd stable"}, 32'(stab_bad), 32'd0);
    chk({nm, " cmd released"}, {30'b0, avm_read, avm_write}, 32'd0);
    if (!we) begin
      for (int n = 0; n < cnt; n++) begin
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) begin
          avm_readdatavalid = 1'b0;
          avm_readdata = $urandom;
          step();
        end
        avm_readdatavalid = 1'b1;
        avm_readdata = pat(base + 32'(4 * n));
        expq.push_back('{base + 32'(4 * n), avm_readdata, cyc + 1});
        step();
      end
      avm_readdatavalid = 1'b0;
    end
    acc_i = 1'b0;
    chk({nm, " idle during ack"}, {31'b0, idle_o}, 32'd0);
    if (we) begin
      step();
      chk({nm, " guard not idle"}, {31'b0, idle_o}, 32'd0);
    end
    step();
    chk({nm, " idle after guard"}, {31'b0, idle_o}, 32'd1);
    chk({nm, " ack count"}, 32'(ackq.size()), 32'(expq.size()));
    for (int n = 0; n < expq.size() && n < ackq.size(); n++) begin
      chk($sformatf("%s ack%0d adr", nm, n), ackq[n].a, expq[n].a);
      chk($sformatf("%s ack%0d cycle", nm, n), 32'(ackq[n].c), 32'(expq[n].c));
      if (!we) chk($sformatf("%s ack%0d dat", nm, n), ackq[n].d, expq[n].d);
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  bw;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    int          max_gap;
    string       nm;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1014, 4'd3,  32'h0,         4'h0, 0, 0, "rd8"};
    vecs[1] = '{1'b1, 32'h0000_2000, 4'd0,  32'hDEADBEEF,  4'h3, 3, 0, "wr_wait3"};
    vecs[2] = '{1'b0, 32'h0000_3008, 4'd2,  32'h0,         4'h0, 1, 3, "rd4_gaps"};
    vecs[3] = '{1'b0, 32'h0001_2345, 4'd12, 32'h0,         4'h0, 0, 0, "rd_clamp"};
    vecs[4] = '{1'b0, 32'h0000_4007, 4'd0,  32'h0,         4'h0, 2, 0, "rd1"};
    vecs[5] = '{1'b0, 32'hFFFF_FFF6, 4'd2,  32'h0,         4'h0, 0, 2, "rd_top"};
    vecs[6] = '{1'b1, 32'h0000_5003, 4'd5,  32'h1234_5678, 4'hC, 0, 0, "wr_unaligned"};

    sdram_rst = 1'b1; acc_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; sel_i = '0;
    buf_width_i = '0; avm_waitrequest = 1'b1; avm_readdata = '0; avm_readdatavalid = 1'b0;
    repeat (3) step();
    chk("reset idle_o", {31'b0, idle_o}, 32'd1);
    chk("reset ack/rd/wr", {29'b0, ack_o, avm_read, avm_write}, 32'd0);
    chk("reset adr_o", adr_o, 32'd0);
    chk("reset dat_o", dat_o, 32'd0);
    chk("reset burstcount", 32'(avm_burstcount), 32'd0);
    sdram_rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++)
      run_access(vecs[i].we, vecs[i].adr, vecs[i].bw, vecs[i].dat, vecs[i].sel,
                 vecs[i].waits, vecs[i].max_gap, 1'b1, vecs[i].nm);

    // Reset arriving together with beat 2 of an 8-beat read.
    wait_idle("rst_mid");
    ackq.delete();
    acc_i = 1'b1; we_i = 1'b0; adr_i = 32'h0000_8010; buf_width_i = 4'd3; avm_waitrequest = 1'b0;
    step();
    step();
    for (int n = 0; n < 3; n++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = pat(32'h8000 + 32'(4 * n));
      if (n == 2) sdram_rst = 1'b1;
      step();
    end
    acc_i = 1'b0;
    chk("rst_mid ack_o in reset", {31'b0, ack_o}, 32'd0);
    chk("rst_mid idle_o in reset", {31'b0, idle_o}, 32'd1);
    sdram_rst = 1'b0;
    for (int n = 3; n < 8; n++) begin
      avm_readdata = pat(32'h8000 + 32'(4 * n));
      step();
    end
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b1;
    repeat (3) step();
    chk("rst_mid ack count", 32'(ackq.size()), 32'd2);
    if (ackq.size() >= 2) chk("rst_mid ack1 adr", ackq[1].a, 32'h0000_8004);
    chk("rst_mid idle after", {31'b0, idle_o}, 32'd1);
    run_access(1'b1, 32'h0000_9000, 4'd0, 32'hCAFE_F00D, 4'hF, 1, 0, 1'b0, "wr_after_rst");

    // acc_i held through GUARD: exactly one non-idle cycle, then the next access starts.
    wait_idle("guard");
    acc_i = 1'b1; we_i = 1'b1; adr_i = 32'h0000_6000; dat_i = 32'h1111_2222; sel_i = 4'hF;
    avm_waitrequest = 1'b0;
    step();
    chk("guard first write", {31'b0, avm_write}, 32'd1);
    step();
    chk("guard ack", {31'b0, ack_o}, 32'd1);
    adr_i = 32'h0000_7000; dat_i = 32'h3333_4444;
    step();
    chk("guard idle low", {31'b0, idle_o}, 32'd0);
    chk("guard no write", {31'b0, avm_write}, 32'd0);
    step();
    chk("guard idle high", {31'b0, idle_o}, 32'd1);
    step();
    chk("guard second write", {31'b0, avm_write}, 32'd1);
    chk("guard second addr", avm_address, 32'h0000_7000);
    step();
    acc_i = 1'b0;
    avm_waitrequest = 1'b1;
    repeat (2) step();
    chk("guard end idle", {31'b0, idle_o}, 32'd1);

    for (int r = 0; r < 25; r++) begin
      bit          rwe;
      logic [3:0]  rbw;
      rwe = ($urandom % 3) == 0;
      rbw = (($urandom % 8) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 4));
      run_access(rwe, $urandom, rbw, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), 1'b1, $sformatf("rnd%0d", r));
    end

    chk("invariants", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
